// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, RAM and status signals around mem_arbiter.
// Requesters: iREN/iaddr -> ihit/iload, dREN/dWEN/daddr/dstore -> dhit/dload.
// RAM: ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in. err is sticky status.
// slave = arbiter view, master = requester/RAM/bench view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction and data accesses onto one single-ported RAM.
// Ports: CLK (rising edge), RST (async active-high), bus (mem_arbiter_if.slave).
// Data side wins unless the instruction side has been passed over STARVE_MAX times.
// RAM errors and timeouts complete the access with ERR_WORD and set sticky err.
module mem_arbiter #(
    parameter int          TIMEOUT    = 64,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, DACC = 2'd1, IACC = 2'd2, RESP = 2'd3;
    localparam logic [1:0] RAM_ACCESS = 2'd2, RAM_ERROR = 2'd3;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    logic [1:0]    r_state;
    logic          r_dside;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tcnt;
    logic [31:0]   r_iload;
    logic [31:0]   r_dload;
    logic          r_err;
    logic          w_dgrant;
    logic          w_dacc;
    logic          w_iacc;
    logic          w_acc;
    logic          w_fail;
    assign w_dgrant = (bus.dREN | bus.dWEN) && !(bus.iREN && r_starve == SW'(STARVE_MAX));
    assign w_dacc   = r_state == DACC;
    assign w_iacc   = r_state == IACC;
    assign w_acc    = bus.ramstate == RAM_ACCESS;
    // ACCESS on the last allowed cycle still counts as success
    assign w_fail   = !w_acc && (bus.ramstate == RAM_ERROR || r_tcnt == TW'(TIMEOUT - 1));
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_dside  <= 1'b0;
            r_starve <= '0;
            r_tcnt   <= '0;
            r_iload  <= '0;
            r_dload  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dgrant) begin
                        r_state  <= DACC;
                        r_dside  <= 1'b1;
                        r_starve <= !bus.iREN ? '0 :
                                    (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + 1'b1;
                    end else if (bus.iREN) begin
                        r_state  <= IACC;
                        r_dside  <= 1'b0;
                        r_starve <= '0;
                    end else begin
                        r_starve <= '0;
                    end
                end
                DACC, IACC: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_acc || w_fail) begin
                        r_state <= RESP;
                        if (w_fail)
                            r_err <= 1'b1;
                        if (w_iacc)
                            r_iload <= w_fail ? ERR_WORD : bus.ramload;
                        else if (!bus.dWEN)
                            r_dload <= w_fail ? ERR_WORD : bus.ramload;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end
    // strobes follow the state directly so reset drops them immediately
    assign bus.ramREN   = w_iacc | (w_dacc & bus.dREN & ~bus.dWEN);
    assign bus.ramWEN   = w_dacc & bus.dWEN;
    assign bus.ramaddr  = w_dacc ? bus.daddr : w_iacc ? bus.iaddr : '0;
    assign bus.ramstore = w_dacc ? bus.dstore : '0;
    assign bus.ihit     = (r_state == RESP) & ~r_dside;
    assign bus.dhit     = (r_state == RESP) & r_dside;
    assign bus.iload    = r_iload;
    assign bus.dload    = r_dload;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int          TIMEOUT    = 64;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;
    localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int tests = 0;
    int fails = 0;
    int          m_starve;
    logic [31:0] m_iload;
    logic [31:0] m_dload;
    logic        m_err;
    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX), .ERR_WORD(ERR_WORD)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        RST = 1'b1;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
        repeat (2) @(negedge CLK);
        m_starve = 0; m_iload = 0; m_dload = 0; m_err = 0;
        RST = 1'b0;
    endtask
    // One complete access: predict grant side and result, act as the RAM, check the hit.
    // lat = ACC cycle on which the RAM answers with kind; lat > TIMEOUT means it never answers.
    task automatic txn(input int lat, input logic [1:0] kind, input logic [31:0] ld,
                       input int exp_k, output logic sd);
        logic pi, wr, fail, hit, prev;
        int n, c;
        logic [31:0] ea;
        pi = bus.iREN;
        wr = bus.dWEN;
        sd = (bus.dREN | bus.dWEN) && !(pi && m_starve == STARVE_MAX);
        m_starve = (sd && pi) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        fail = (lat > TIMEOUT) || (kind == ERROR);
        n = (lat > TIMEOUT) ? TIMEOUT : lat;
        ea = sd ? bus.daddr : bus.iaddr;
        if (!sd) m_iload = fail ? ERR_WORD : ld;
        else if (!wr) m_dload = fail ? ERR_WORD : ld;
        m_err = m_err | fail;
        c = 0; hit = 0; prev = 0;
        for (int k = 1; k <= TIMEOUT + 10 && !hit; k++) begin
            @(negedge CLK);
            if (bus.ihit || bus.dhit) begin
                hit = 1;
                chk("hit_exclusive", bus.ihit & bus.dhit, 0);
                chk("hit_side", bus.dhit, sd);
                chk("hit_follows_access", prev, 1);
                chk("access_cycles", c, n);
                if (exp_k > 0) chk("latency", k, exp_k);
                chk("iload", bus.iload, m_iload);
                chk("dload", bus.dload, m_dload);
                chk("err", bus.err, m_err);
                chk("strobes_in_resp", {bus.ramREN, bus.ramWEN}, 0);
                bus.ramstate = FREE;
            end else if (bus.ramREN || bus.ramWEN) begin
                c++;
                prev = 1;
                chk("ramaddr", bus.ramaddr, ea);
                chk("ramREN", bus.ramREN, !(sd && wr));
                chk("ramWEN", bus.ramWEN, sd && wr);
                if (sd && wr) chk("ramstore", bus.ramstore, bus.dstore);
                bus.ramstate = (c == lat) ? kind : BUSY;
                bus.ramload = ld;
            end else begin
                prev = 0;
                bus.ramstate = FREE;
            end
        end
        chk("hit_seen", hit, 1);
        if (sd) begin bus.dREN = 0; bus.dWEN = 0; end
        else bus.iREN = 0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic sd;
        int r, lat, m;
        logic [1:0] kind;
        do_reset();
        RST = 1'b1;
        #1;
        chk("rst_outputs", {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.err}, 0);
        chk("rst_loads", bus.iload | bus.dload | bus.ramaddr | bus.ramstore, 0);
        do_reset();
        // single instruction fetch, RAM answers on 2nd IACC cycle
        bus.iREN = 1; bus.iaddr = 32'h40;
        txn(2, ACCESS, 32'h8C220004, 3, sd);
        chk("fetch_iload", bus.iload, 32'h8C220004);
        // simultaneous requests: data first, then instruction
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100;
        txn(1, ACCESS, 32'h11112222, 2, sd);
        chk("data_first", sd, 1);
        txn(1, ACCESS, 32'h33334444, 0, sd);
        chk("instr_second", sd, 0);
        // anti-starvation with a continuous writer
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hCAFE0001;
        for (int j = 0; j < 5; j++) begin
            txn(1 + j % 2, ACCESS, $urandom, 0, sd);
            chk($sformatf("starve_order_%0d", j), sd, j < 4);
            bus.dWEN = 1;
        end
        txn(1, ACCESS, $urandom, 0, sd);
        chk("writer_after_fetch", sd, 1);
        // RAM stuck busy on a fetch
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'hC0;
        txn(1000, ACCESS, 32'h0, TIMEOUT + 1, sd);
        chk("timeout_iload", bus.iload, ERR_WORD);
        repeat (3) @(negedge CLK);
        chk("err_sticky", bus.err, 1);
        bus.dREN = 1; bus.daddr = 32'h10;
        txn(1, ACCESS, 32'h5A5A5A5A, 0, sd);
        chk("err_still_set", bus.err, 1);
        // RAM error on a data read
        do_reset();
        bus.dREN = 1; bus.daddr = 32'h300;
        txn(1, ERROR, 32'h12345678, 2, sd);
        chk("error_dload", bus.dload, ERR_WORD);
        chk("error_err", bus.err, 1);
        // reset in the middle of a data write
        do_reset();
        bus.dWEN = 1; bus.daddr = 32'h44; bus.dstore = 32'h77;
        @(negedge CLK);
        bus.ramstate = BUSY;
        chk("pre_rst_wen", bus.ramWEN, 1);
        #1 RST = 1'b1;
        #1;
        chk("rst_drops_strobes", {bus.ramREN, bus.ramWEN}, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        repeat (2) begin
            @(negedge CLK);
            chk("rst_no_hit", {bus.ihit, bus.dhit}, 0);
        end
        bus.dWEN = 0; bus.ramstate = FREE;
        m_starve = 0; m_iload = 0; m_dload = 0; m_err = 0;
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("post_rst_quiet", {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.err}, 0);
        end
        bus.iREN = 1; bus.iaddr = 32'h48;
        txn(1, ACCESS, 32'hABCD0123, 2, sd);
        // randomized mix of requests and RAM behaviour
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if (!bus.iREN && $urandom % 2 == 0) begin
                bus.iREN = 1; bus.iaddr = $urandom;
            end
            if (!(bus.dREN | bus.dWEN) && $urandom % 2 == 0) begin
                m = $urandom % 3;
                bus.dREN = (m != 1); bus.dWEN = (m != 0);
                bus.daddr = $urandom; bus.dstore = $urandom;
            end
            if (!(bus.iREN | bus.dREN | bus.dWEN)) begin
                bus.iREN = 1; bus.iaddr = $urandom;
            end
            r = $urandom % 16;
            kind = ACCESS;
            if (r < 11) lat = 1 + $urandom % 4;
            else if (r < 13) lat = TIMEOUT;
            else if (r == 13) lat = 1000;
            else begin lat = 1 + $urandom % 3; kind = ERROR; end
            txn(lat, kind, $urandom, 0, sd);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential two-requester memory arbiter; produces the `ihit`/`dhit` handshakes the pipeline hazard logic consumes.
- Sits between the instruction-fetch port, the data-memory port and the single-ported RAM.
- Serialises accesses: data side has priority, instruction side is protected by an anti-starvation counter.
- Detects RAM errors and timeouts and completes the stalled access so the pipeline never hangs.

Parameters:
- TIMEOUT, 64, max cycles an access may wait for ramstate==ACCESS before forced completion.
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before the instruction side is forced a grant.
- ERR_WORD, 32'hBAD1BAD1, load value returned on error/timeout completion.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit; dREN&dWEN treated as write.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ihit  out  1  one-cycle pulse: instruction access complete, iload valid.
- iload  out  32  instruction word, registered.
- dhit  out  1  one-cycle pulse: data access complete, dload valid.
- dload  out  32  data read value, registered; for writes, holds previous value.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky; set on any ERROR/timeout, cleared only by RST.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0; iload=dload=0; starvation counter=0; timeout counter=0; err=0.
  - Reset mid-access drops the RAM strobes the same instant; no hit is produced.
- States: IDLE, DACC, IACC, RESP.
- IDLE:
  - If (dREN|dWEN) and not (iREN && starve==STARVE_MAX): go DACC.
  - Else if iREN: go IACC.
  - Else: stay.
  - Decision is registered; strobes assert the cycle after the request is first seen.
- DACC: drive ramaddr=daddr; ramWEN=dWEN, ramREN=dREN&~dWEN; ramstore=dstore.
- IACC: drive ramaddr=iaddr, ramREN=1.
- Strobes are combinational from the state only; they are 0 in IDLE and RESP.
- In DACC/IACC, the timeout counter increments each cycle. Exit when:
  - ramstate==ACCESS: capture ramload into dload (data read) or iload; go RESP.
  - ramstate==ERROR, or counter reaches TIMEOUT-1 without ACCESS: load target gets ERR_WORD (writes leave dload unchanged); set err; go RESP.
  - ACCESS and ERROR never coincide (one encoding); ACCESS on the final timeout cycle counts as success.
- RESP: lasts exactly one cycle; dhit or ihit = 1 per the completed side; strobes 0; timeout counter cleared; go IDLE.
- Minimum request-to-hit latency: 3 cycles (IDLE sample, ACC with ACCESS, RESP).
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each DACC entry while iREN=1.
  - Cleared on IACC entry or when iREN=0 in IDLE.
- Request withdrawal during DACC/IACC: the access still completes and the hit still pulses; requesters must ignore it.
- ihit and dhit are never high in the same cycle.
- Address/data changes during an access are not required to be stable; the arbiter presents the live values.

Test Plan:
- iREN=1, iaddr=0x40; RAM returns ACCESS on the 2nd IACC cycle with ramload=0x8C220004 -> ihit pulses 1 cycle; iload=0x8C220004; ramREN was high exactly 2 cycles.
- iREN and dREN both high from reset release, daddr=0x100 -> DACC served first, dhit; then IACC, ihit; no overlapping strobes.
- dWEN held continuously with iREN=1, STARVE_MAX=4 -> after the 4th dhit, next grant is IACC; ihit occurs before the 5th dhit.
- ramstate stuck BUSY during an IACC -> after exactly TIMEOUT cycles in IACC, ihit pulses, iload=0xBAD1BAD1, err=1 and stays 1.
- ramstate=ERROR on a data read -> dhit next cycle, dload=0xBAD1BAD1, err=1.
- RST asserted during DACC -> ramWEN/ramREN drop immediately; no dhit; arbiter in IDLE after release.
